// File: rtl/apb_intc.sv
// rtl/apb_intc.sv - APB interrupt controller with per-line edge/level mode, W1C pending and registered IRQ
module apb_intc #(
    parameter int NUM_IRQS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PENABLE,
    input  logic                PSEL,
    input  logic                PWRITE,
    input  logic [3:0]          PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                IRQ
);

    localparam logic [1:0] ADDR_ACTIVE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_ENABLE  = 2'd2;
    localparam logic [1:0] ADDR_TYPE    = 2'd3;

    logic [NUM_IRQS-1:0] irq_q;
    logic [NUM_IRQS-1:0] pending;
    logic [NUM_IRQS-1:0] enable;
    logic [NUM_IRQS-1:0] edge_mode;
    logic [NUM_IRQS-1:0] pending_next;
    logic [NUM_IRQS-1:0] enable_next;
    logic [NUM_IRQS-1:0] edge_mode_next;
    logic [NUM_IRQS-1:0] w1c;
    logic [NUM_IRQS-1:0] rise;
    logic                armed;
    logic                wr_en;
    logic [4:0]          active_idx;
    logic                active_none;
    logic                unused_bits;

    assign wr_en = PSEL & PENABLE & PWRITE;

    always_comb begin
        enable_next    = enable;
        edge_mode_next = edge_mode;
        w1c            = '0;
        if (wr_en) begin
            case (PADDR[3:2])
                ADDR_PENDING: w1c            = PWDATA[NUM_IRQS-1:0];
                ADDR_ENABLE:  enable_next    = PWDATA[NUM_IRQS-1:0];
                ADDR_TYPE:    edge_mode_next = PWDATA[NUM_IRQS-1:0];
                default:      ;
            endcase
        end
    end

    // irq_q is zero straight after reset, so a line held high through reset
    // would look like a fresh rise; armed masks that first cycle.
    assign rise = irq_in & ~irq_q & {NUM_IRQS{armed}};

    // The mode taking effect this edge decides the update, so a level-to-edge
    // switch keeps the current pending value and set beats same-cycle W1C.
    always_comb begin
        pending_next = pending;
        for (int n = 0; n < NUM_IRQS; n++) begin
            if (edge_mode_next[n]) begin
                pending_next[n] = rise[n] | (pending[n] & ~w1c[n]);
            end else begin
                pending_next[n] = irq_in[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= '0;
            pending   <= '0;
            enable    <= '0;
            edge_mode <= '0;
            armed     <= 1'b0;
            IRQ       <= 1'b0;
        end else begin
            irq_q     <= irq_in;
            pending   <= pending_next;
            enable    <= enable_next;
            edge_mode <= edge_mode_next;
            armed     <= 1'b1;
            IRQ       <= |(pending & enable);
        end
    end

    // Descending scan so the lowest qualifying line is the last one written.
    always_comb begin
        active_none = 1'b1;
        active_idx  = 5'd0;
        for (int n = NUM_IRQS - 1; n >= 0; n--) begin
            if (pending[n] && enable[n]) begin
                active_none = 1'b0;
                active_idx  = n[4:0];
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        case (PADDR[3:2])
            ADDR_ACTIVE:  PRDATA = {active_none, 26'd0, active_idx};
            ADDR_PENDING: PRDATA[NUM_IRQS-1:0] = pending;
            ADDR_ENABLE:  PRDATA[NUM_IRQS-1:0] = enable;
            ADDR_TYPE:    PRDATA[NUM_IRQS-1:0] = edge_mode;
            default:      PRDATA = '0;
        endcase
    end

    assign unused_bits = ^{PADDR[1:0], PWDATA[31:NUM_IRQS]};

endmodule

// File: tb/tb_apb_intc.sv
// tb/tb_apb_intc.sv - self-checking bench for apb_intc: behavioural model, directed scenarios, random stimulus
module tb_apb_intc;

    localparam int N = 8;
    localparam logic [31:0] MASK = (32'd1 << N) - 32'd1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         PENABLE = 1'b0;
    logic         PSEL = 1'b0;
    logic         PWRITE = 1'b0;
    logic [3:0]   PADDR = 4'd0;
    logic [31:0]  PWDATA = 32'd0;
    logic [31:0]  PRDATA;
    logic [N-1:0] irq_in = '0;
    logic         IRQ;

    apb_intc #(.NUM_IRQS(N)) dut (
        .clk(clk), .reset(reset), .PENABLE(PENABLE), .PSEL(PSEL), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .irq_in(irq_in), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    // Model state, written only by the model process.
    bit [31:0] m_pend, m_en, m_type, m_prev;
    bit        m_irq, m_armed, m_valid;

    always @(posedge clk) begin
        bit        wr, new_irq, rise;
        bit [1:0]  a;
        bit [31:0] n_en, n_type;
        if (reset) begin
            m_pend = 0; m_en = 0; m_type = 0; m_prev = 0; m_irq = 0; m_armed = 0;
        end else begin
            wr = PSEL && PENABLE && PWRITE;
            a = PADDR[3:2];
            new_irq = (m_pend & m_en) != 0;
            n_en = m_en;
            n_type = m_type;
            if (wr && a == 2) n_en = PWDATA & MASK;
            if (wr && a == 3) n_type = PWDATA & MASK;
            for (int i = 0; i < N; i++) begin
                if (n_type[i]) begin
                    rise = m_armed && irq_in[i] && !m_prev[i];
                    if (rise) m_pend[i] = 1'b1;
                    else if (wr && a == 1 && PWDATA[i]) m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = irq_in[i];
                end
            end
            m_en = n_en;
            m_type = n_type;
            m_irq = new_irq;
            m_prev = 32'(irq_in);
            m_armed = 1'b1;
        end
        m_valid = 1'b1;
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] addr);
        bit [31:0] q;
        case (addr[3:2])
            2'd0: begin
                q = m_pend & m_en;
                if (q == 0) return 32'h8000_0000;
                for (int i = 0; i < 32; i++) if (q[i]) return 32'(i);
                return 32'h8000_0000;
            end
            2'd1: return m_pend;
            2'd2: return m_en;
            default: return m_type;
        endcase
    endfunction

    // Literal expectations posted by the stimulus process.
    bit          lit_pend = 1'b0;
    string       lit_name = "";
    logic [31:0] lit_rd = 32'd0;
    bit          lit_irq_chk = 1'b0;
    bit          lit_irq = 1'b0;

    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (PRDATA !== exp_rd(PADDR)) begin
                errors++;
                $display("FAIL model_prdata addr=%h: got %h want %h at %0t", PADDR, PRDATA, exp_rd(PADDR), $time);
            end
            checks++;
            if (IRQ !== m_irq) begin
                errors++;
                $display("FAIL model_irq: got %b want %b at %0t", IRQ, m_irq, $time);
            end
        end
        if (lit_pend) begin
            checks++;
            if (PRDATA !== lit_rd) begin
                errors++;
                $display("FAIL %s prdata: got %h want %h", lit_name, PRDATA, lit_rd);
            end
            if (lit_irq_chk) begin
                checks++;
                if (IRQ !== lit_irq) begin
                    errors++;
                    $display("FAIL %s irq: got %b want %b", lit_name, IRQ, lit_irq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1;
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic check_lit(input string nm, input logic [3:0] a, input logic [31:0] e,
                             input bit ic, input bit ie);
        PADDR = a; PSEL = 1; PENABLE = 1; PWRITE = 0;
        lit_name = nm; lit_rd = e; lit_irq_chk = ic; lit_irq = ie; lit_pend = 1;
        @(negedge clk);
        #1;
        lit_pend = 0; PSEL = 0; PENABLE = 0;
    endtask

    initial begin
        tick(); tick();
        check_lit("reset_active", 4'h0, 32'h8000_0000, 1, 0);
        reset = 0;

        // Level line 0: pending one cycle after the rise, IRQ one more, falls the same way.
        wr(4'h8, 32'h01);
        wr(4'hC, 32'h00);
        irq_in[0] = 1;
        tick();
        check_lit("lvl_pending", 4'h4, 32'h01, 1, 0);
        tick();
        check_lit("lvl_active", 4'h0, 32'h0, 1, 1);
        irq_in[0] = 0;
        tick();
        check_lit("lvl_drop1", 4'h4, 32'h00, 1, 1);
        tick();
        check_lit("lvl_drop2", 4'h4, 32'h00, 1, 0);

        // Edge line 2: pulse latches, W1C clears.
        wr(4'hC, 32'h04);
        wr(4'h8, 32'h04);
        irq_in[2] = 1;
        tick();
        irq_in[2] = 0;
        tick();
        check_lit("edge_held", 4'h4, 32'h04, 1, 1);
        tick();
        check_lit("edge_held2", 4'h4, 32'h04, 1, 1);
        wr(4'h4, 32'h04);
        check_lit("w1c_clear", 4'h4, 32'h00, 1, 1);
        tick();
        check_lit("w1c_irq", 4'h0, 32'h8000_0000, 1, 0);

        // Rise and W1C on the same edge: set wins.
        PSEL = 1; PWRITE = 1; PADDR = 4'h4; PWDATA = 32'h04; PENABLE = 0;
        tick();
        PENABLE = 1; irq_in[2] = 1;
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0; irq_in[2] = 0;
        check_lit("set_wins", 4'h4, 32'h04, 1, 0);
        wr(4'h4, 32'h04);

        // Priority: lines 5 and 3.
        wr(4'hC, 32'hFF);
        wr(4'h8, 32'hFF);
        irq_in = 8'h28;
        tick();
        irq_in = 8'h00;
        tick();
        check_lit("prio_3", 4'h0, 32'h03, 1, 1);
        wr(4'h8, 32'h20);
        check_lit("prio_5", 4'h0, 32'h05, 1, 1);
        wr(4'h8, 32'h00);
        check_lit("prio_none", 4'h0, 32'h8000_0000, 1, 1);
        tick();
        check_lit("prio_irq0", 4'h0, 32'h8000_0000, 1, 0);
        wr(4'h4, 32'hFF);

        // Pending latches while masked; enabling raises IRQ one cycle later.
        wr(4'hC, 32'h00);
        irq_in[1] = 1;
        tick(); tick();
        check_lit("masked_pend", 4'h4, 32'h02, 1, 0);
        wr(4'h8, 32'h02);
        check_lit("enable_edge", 4'h8, 32'h02, 1, 0);
        tick();
        check_lit("enable_irq", 4'h0, 32'h01, 1, 1);
        irq_in[1] = 0;

        // Reset mid-operation.
        wr(4'h8, 32'hFF);
        irq_in = 8'hFF;
        tick(); tick();
        check_lit("pre_reset", 4'h4, 32'hFF, 1, 1);
        reset = 1;
        tick();
        reset = 0;
        check_lit("rst_pending", 4'h4, 32'h00, 1, 0);
        check_lit("rst_enable", 4'h8, 32'h00, 1, 0);
        check_lit("rst_type", 4'hC, 32'h00, 1, 0);
        check_lit("rst_active", 4'h0, 32'h8000_0000, 1, 0);

        // Line held high through reset must not look like an edge.
        reset = 1;
        PSEL = 1; PWRITE = 1; PADDR = 4'hC; PWDATA = 32'hFF; PENABLE = 0;
        tick();
        reset = 0; PENABLE = 1;
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        tick();
        check_lit("held_no_edge", 4'h4, 32'h00, 1, 0);
        irq_in[4] = 0;
        tick();
        irq_in[4] = 1;
        tick();
        check_lit("re_rise", 4'h4, 32'h10, 0, 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            tick();
            reset   = ($urandom_range(0, 99) == 0);
            PSEL    = $urandom_range(0, 1);
            PENABLE = $urandom_range(0, 1);
            PWRITE  = $urandom_range(0, 1);
            PADDR   = 4'($urandom);
            PWDATA  = $urandom;
            if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ N'($urandom);
        end
        tick();
        reset = 0; PSEL = 0; PENABLE = 0; PWRITE = 0;
        tick(); tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
